// File: rtl/freq_mon_if.sv
// Bundles the divided-clock inputs, the clear strobe and the status outputs of the
// divided-clock frequency monitor.
interface freq_mon_if;
  logic       CLK_50;
  logic       CLK_10;
  logic       CLK_1;
  logic       CLR;
  logic [2:0] LOCK;
  logic       ALL_LOCK;
  logic [2:0] ERR_SHORT;
  logic [2:0] ERR_LONG;

  modport master (
    output CLK_50, CLK_10, CLK_1, CLR,
    input  LOCK, ALL_LOCK, ERR_SHORT, ERR_LONG
  );

  modport slave (
    input  CLK_50, CLK_10, CLK_1, CLR,
    output LOCK, ALL_LOCK, ERR_SHORT, ERR_LONG
  );
endinterface

// File: rtl/freq_mon.sv
// Measures half-periods of the /2, /10 and /100 divider outputs in CLK_in cycles,
// raising sticky short/long errors and a per-channel lock after enough good intervals.
module freq_mon #(
  parameter int unsigned HALF_50  = 32'd1,
  parameter int unsigned HALF_10  = 32'd5,
  parameter int unsigned HALF_1   = 32'd50,
  parameter int unsigned LOCK_CNT = 32'd4
) (
  input  logic      CLK_in,
  input  logic      RST,
  freq_mon_if.slave mon
);

  typedef enum logic [1:0] {
    ST_UNARMED = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKED  = 2'd2
  } ch_state_t;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_CNT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    if (v >= lim) begin
      sat_inc4 = lim;
    end else begin
      sat_inc4 = v + 4'd1;
    end
  endfunction

  logic [2:0] in_s;
  logic [2:0] lock_s;
  logic [2:0] err_short_s;
  logic [2:0] err_long_s;
  logic       all_lock_r;

  assign in_s = {mon.CLK_1, mon.CLK_10, mon.CLK_50};

  for (genvar g = 0; g < 3; g++) begin : g_ch
    localparam int unsigned H = (g == 32'sd0) ? HALF_50 : ((g == 32'sd1) ? HALF_10 : HALF_1);
    localparam logic [8:0] H_INT  = 9'(H);
    localparam logic [7:0] H_LAST = 8'(H - 32'd1);

    logic       prev_r;
    logic [7:0] cnt_r;
    ch_state_t  state_r;
    logic [3:0] good_r;
    logic       lock_r;
    logic       err_short_r;
    logic       err_long_r;

    logic       tog_s;
    logic [8:0] interval_s;
    logic [3:0] good_inc_s;
    logic [7:0] cnt_nxt_s;
    ch_state_t  state_nxt_s;
    logic [3:0] good_nxt_s;
    logic       err_short_nxt_s;
    logic       err_long_nxt_s;

    // Next-state, interval check and sticky error update for this channel
    always_comb begin
      tog_s           = (in_s[g] != prev_r);
      interval_s      = {1'b0, cnt_r} + 9'd1;
      good_inc_s      = sat_inc4(good_r, LOCK_LIM);
      state_nxt_s     = state_r;
      good_nxt_s      = good_r;
      err_short_nxt_s = err_short_r;
      err_long_nxt_s  = err_long_r;

      if (tog_s) begin
        cnt_nxt_s = 8'd0;
      end else begin
        cnt_nxt_s = sat_inc8(cnt_r);
      end

      // Clear beats any same-cycle event and leaves the channel waiting for a fresh edge.
      if (mon.CLR) begin
        state_nxt_s     = ST_UNARMED;
        good_nxt_s      = 4'd0;
        err_short_nxt_s = 1'b0;
        err_long_nxt_s  = 1'b0;
      end else begin
        case (state_r)
          ST_UNARMED: begin
            if (tog_s) begin
              state_nxt_s = ST_ARMED;
            end else begin
              state_nxt_s = ST_UNARMED;
            end
          end
          ST_ARMED, ST_LOCKED: begin
            if (tog_s) begin
              if (interval_s == H_INT) begin
                good_nxt_s = good_inc_s;
                if (good_inc_s == LOCK_LIM) begin
                  state_nxt_s = ST_LOCKED;
                end else begin
                  state_nxt_s = state_r;
                end
              end else if (interval_s < H_INT) begin
                err_short_nxt_s = 1'b1;
                good_nxt_s      = 4'd0;
                state_nxt_s     = ST_ARMED;
              end else begin
                // Overlong interval was already reported by the timeout; just restart.
                state_nxt_s = state_r;
              end
            end else if (cnt_r == H_LAST) begin
              err_long_nxt_s = 1'b1;
              good_nxt_s     = 4'd0;
              state_nxt_s    = ST_ARMED;
            end else begin
              state_nxt_s = state_r;
            end
          end
          default: begin
            state_nxt_s = ST_UNARMED;
            good_nxt_s  = 4'd0;
          end
        endcase
      end
    end

    // Channel state, counter and registered status outputs
    always_ff @(posedge CLK_in or negedge RST) begin
      if (!RST) begin
        prev_r      <= 1'b0;
        cnt_r       <= 8'd0;
        state_r     <= ST_UNARMED;
        good_r      <= 4'd0;
        lock_r      <= 1'b0;
        err_short_r <= 1'b0;
        err_long_r  <= 1'b0;
      end else begin
        prev_r      <= in_s[g];
        cnt_r       <= cnt_nxt_s;
        state_r     <= state_nxt_s;
        good_r      <= good_nxt_s;
        lock_r      <= (state_nxt_s == ST_LOCKED);
        err_short_r <= err_short_nxt_s;
        err_long_r  <= err_long_nxt_s;
      end
    end

    assign lock_s[g]      = lock_r;
    assign err_short_s[g] = err_short_r;
    assign err_long_s[g]  = err_long_r;
  end

  // Aggregate lock, one cycle behind the per-channel lock bits
  always_ff @(posedge CLK_in or negedge RST) begin
    if (!RST) begin
      all_lock_r <= 1'b0;
    end else if (mon.CLR) begin
      all_lock_r <= 1'b0;
    end else begin
      all_lock_r <= &lock_s;
    end
  end

  assign mon.LOCK      = lock_s;
  assign mon.ALL_LOCK  = all_lock_r;
  assign mon.ERR_SHORT = err_short_s;
  assign mon.ERR_LONG  = err_long_s;

endmodule

// File: tb/tb_freq_mon.sv
// Directed bench for freq_mon: ideal divider start-up, stall, short pulse, clear,
// clear racing a timeout, and asynchronous reset mid-run.
module tb_freq_mon;
  logic CLK_in;
  logic RST;

  freq_mon_if mon_if ();

  freq_mon #(
    .HALF_50 (32'd1),
    .HALF_10 (32'd5),
    .HALF_1  (32'd50),
    .LOCK_CNT(32'd4)
  ) dut (
    .CLK_in(CLK_in),
    .RST   (RST),
    .mon   (mon_if)
  );

  initial CLK_in = 1'b0;
  always #5 CLK_in = ~CLK_in;

  int         n_cmp;
  int         n_err;
  int         cyc;
  logic [2:0] lvl;
  int         cnt_tb  [3];
  int         half_tb [3];
  bit         frz     [3];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] lk, input logic al,
                         input logic [2:0] es, input logic [2:0] el);
    chk({tag, ".LOCK"},      {5'd0, mon_if.LOCK},      {5'd0, lk});
    chk({tag, ".ALL_LOCK"},  {7'd0, mon_if.ALL_LOCK},  {7'd0, al});
    chk({tag, ".ERR_SHORT"}, {5'd0, mon_if.ERR_SHORT}, {5'd0, es});
    chk({tag, ".ERR_LONG"},  {5'd0, mon_if.ERR_LONG},  {5'd0, el});
  endtask

  task automatic drive();
    mon_if.CLK_50 = lvl[0];
    mon_if.CLK_10 = lvl[1];
    mon_if.CLK_1  = lvl[2];
  endtask

  task automatic model_reset();
    lvl        = 3'b000;
    half_tb[0] = 1;
    half_tb[1] = 5;
    half_tb[2] = 50;
    for (int i = 0; i < 3; i++) begin
      cnt_tb[i] = 0;
      frz[i]    = 1'b0;
    end
    cyc        = 0;
    mon_if.CLR = 1'b0;
    drive();
  endtask

  // Advance one CLK_in cycle; new levels are applied 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK_in);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!frz[i]) begin
        cnt_tb[i]++;
        if (cnt_tb[i] >= half_tb[i]) begin
          lvl[i]    = ~lvl[i];
          cnt_tb[i] = 0;
        end
      end
    end
    drive();
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic force_toggle(input int ch);
    lvl[ch]    = ~lvl[ch];
    cnt_tb[ch] = 0;
    frz[ch]    = 1'b0;
    drive();
  endtask

  // Ideal dividers from reset: ch0 locks at 6, ch1 at 26, ch2 at 251, ALL_LOCK at 252.
  task automatic check_startup(input string tag, input int last);
    run_to(5);   chk({tag, "_l0_pre"}, {5'd0, mon_if.LOCK}, 8'h00);
    run_to(6);   chk({tag, "_l0"},     {5'd0, mon_if.LOCK}, 8'h01);
    run_to(25);  chk({tag, "_l1_pre"}, {5'd0, mon_if.LOCK}, 8'h01);
    run_to(26);  chk({tag, "_l1"},     {5'd0, mon_if.LOCK}, 8'h03);
    run_to(250); chk_all({tag, "_250"}, 3'b011, 1'b0, 3'b000, 3'b000);
    run_to(251); chk_all({tag, "_251"}, 3'b111, 1'b0, 3'b000, 3'b000);
    run_to(252); chk_all({tag, "_252"}, 3'b111, 1'b1, 3'b000, 3'b000);
    run_to(last); chk_all({tag, "_end"}, 3'b111, 1'b1, 3'b000, 3'b000);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST   = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK_in);
    chk_all("rst", 3'b000, 1'b0, 3'b000, 3'b000);
    RST = 1'b1;

    // 1: ideal start-up
    check_startup("s1", 2000);

    // 2: CLK_10 frozen after its toggle at edge 2001, timeout at edge 2006
    run_to(2001);
    frz[1] = 1'b1;
    run_to(2005); chk_all("s2_pre",  3'b111, 1'b1, 3'b000, 3'b000);
    run_to(2006); chk_all("s2_to",   3'b101, 1'b1, 3'b000, 3'b010);
    run_to(2007); chk_all("s2_all",  3'b101, 1'b0, 3'b000, 3'b010);
    run_to(2020);
    force_toggle(1);
    run_to(2021); chk_all("s2_rel",  3'b101, 1'b0, 3'b000, 3'b010);
    run_to(2040); chk("s2_relock_pre", {5'd0, mon_if.LOCK}, 8'h05);
    run_to(2041); chk("s2_relock",     {5'd0, mon_if.LOCK}, 8'h07);

    // 3: CLK_1 half-period of 49 sampled at edge 2100
    run_to(2051);
    half_tb[2] = 49;
    run_to(2099);
    half_tb[2] = 50;
    chk_all("s3_pre",  3'b111, 1'b1, 3'b000, 3'b010);
    run_to(2100); chk_all("s3_err",  3'b011, 1'b1, 3'b100, 3'b010);
    run_to(2101); chk("s3_all", {7'd0, mon_if.ALL_LOCK}, 8'h00);
    run_to(2299); chk("s3_relock_pre", {5'd0, mon_if.LOCK}, 8'h03);
    run_to(2300); chk_all("s3_relock", 3'b111, 1'b0, 3'b100, 3'b010);
    run_to(2301); chk("s3_all_relock", {7'd0, mon_if.ALL_LOCK}, 8'h01);

    // 4: CLR with errors set, sampled at edge 2401
    run_to(2400); chk_all("s4_pre", 3'b111, 1'b1, 3'b100, 3'b010);
    mon_if.CLR = 1'b1;
    tick();
    mon_if.CLR = 1'b0;
    chk_all("s4_clr", 3'b000, 1'b0, 3'b000, 3'b000);
    run_to(2405); chk("s4_l0_pre", {5'd0, mon_if.LOCK}, 8'h00);
    run_to(2406); chk("s4_l0",     {5'd0, mon_if.LOCK}, 8'h01);
    run_to(2425); chk("s4_l1_pre", {5'd0, mon_if.LOCK}, 8'h01);
    run_to(2426); chk("s4_l1",     {5'd0, mon_if.LOCK}, 8'h03);
    run_to(2649); chk("s4_l2_pre", {5'd0, mon_if.LOCK}, 8'h03);
    run_to(2650); chk("s4_l2",     {5'd0, mon_if.LOCK}, 8'h07);
    run_to(2651); chk_all("s4_all", 3'b111, 1'b1, 3'b000, 3'b000);

    // 5: CLR on the CLK_10 timeout edge 2706
    run_to(2701);
    frz[1] = 1'b1;
    run_to(2705);
    mon_if.CLR = 1'b1;
    tick();
    mon_if.CLR = 1'b0;
    chk_all("s5_clr", 3'b000, 1'b0, 3'b000, 3'b000);
    run_to(2710); chk("s5_el_hold", {5'd0, mon_if.ERR_LONG}, 8'h00);
    force_toggle(1);
    run_to(2730); chk("s5_l1_pre", {7'd0, mon_if.LOCK[1]}, 8'h00);
    run_to(2731); chk_all("s5_l1", 3'b011, 1'b0, 3'b000, 3'b000);

    // 6: asynchronous reset mid-run, then start-up again
    run_to(2760); chk("s6_pre", {5'd0, mon_if.LOCK}, 8'h03);
    #2;
    RST = 1'b0;
    #1;
    chk_all("s6_async", 3'b000, 1'b0, 3'b000, 3'b000);
    model_reset();
    repeat (3) @(negedge CLK_in);
    chk_all("s6_held", 3'b000, 1'b0, 3'b000, 3'b000);
    RST = 1'b1;
    check_startup("s6", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
